// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding and Q-format constants for neuron datapaths
package nn_pkg;

    typedef enum logic [1:0] {
        S_ACC,
        S_DRAIN,
        S_BIAS
    } mac_state_t;

    localparam int FRAC_BITS = 12;
    localparam int DATA_W    = 16;

endpackage

// File: rtl/neuron_mac_relu_sat.sv
// relu_sat: ReLU on a Q-format sum, floor shift back to data format, clamp to max positive
module relu_sat #(
    parameter int accWidth  = 38,
    parameter int dataWidth = 16,
    parameter int fracBits  = 12
) (
    input  logic signed [accWidth-1:0]  sum_i,
    output logic        [dataWidth-1:0] out_o
);

    localparam logic [dataWidth-1:0] MAX_POS = {1'b0, {(dataWidth-1){1'b1}}};

    logic signed [accWidth-1:0] shifted;
    logic                       neg;
    logic                       ovf;

    // arithmetic shift floors toward -inf; negatives are zeroed anyway
    assign shifted = sum_i >>> fracBits;
    assign neg     = sum_i[accWidth-1];
    // any set bit at or above the output sign position means the value exceeds MAX_POS
    assign ovf     = |shifted[accWidth-1:dataWidth-1];
    assign out_o   = neg ? '0 : (ovf ? MAX_POS : shifted[dataWidth-1:0]);

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron MAC fed by a 1-cycle weight ROM, with bias, ReLU and saturation
module neuron_mac
    import nn_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int dataWidth    = DATA_W,
    parameter int fracBits     = FRAC_BITS,
    parameter int addressWidth = $clog2(numWeight)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           x_valid,
    input  logic signed [dataWidth-1:0]    x_in,
    output logic                           x_ready,
    input  logic signed [dataWidth-1:0]    bias,
    output logic                           w_ren,
    output logic        [addressWidth-1:0] w_radd,
    input  logic signed [dataWidth-1:0]    w_rdata,
    output logic                           out_valid,
    output logic        [dataWidth-1:0]    out_data
);

    localparam int ACC_W = 2 * dataWidth + $clog2(numWeight);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

    mac_state_t                    state_q, state_d;
    logic        [addressWidth-1:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [dataWidth-1:0]    xd_q, xd_d;
    logic                           vd_q, vd_d;
    logic                           out_valid_q, out_valid_d;
    logic        [dataWidth-1:0]    out_data_q, out_data_d;
    logic                           accept;
    logic signed [2*dataWidth-1:0]  prod;
    logic signed [SUM_W-1:0]        sum;
    logic        [dataWidth-1:0]    relu_out;

    assign x_ready   = (state_q == S_ACC) && !rst;
    assign accept    = x_valid && x_ready;
    assign w_ren     = accept;
    assign w_radd    = cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // the delayed activation lines up with the ROM word read on the accept cycle
    assign prod = xd_q * w_rdata;
    // bias is promoted into the accumulator's Q format before the add
    assign sum  = SUM_W'(acc_q) + (SUM_W'(bias) <<< fracBits);

    relu_sat #(
        .accWidth (SUM_W),
        .dataWidth(dataWidth),
        .fracBits (fracBits)
    ) u_relu (
        .sum_i(sum),
        .out_o(relu_out)
    );

    // next-state: FSM, address counter, operand delay stage, accumulator and result register
    always_comb begin
        state_d     = state_q;
        cnt_d       = accept ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        xd_d        = accept ? x_in : xd_q;
        vd_d        = accept;
        acc_d       = vd_q ? acc_q + ACC_W'(prod) : acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            S_ACC:   state_d = (accept && cnt_q == LAST) ? S_DRAIN : S_ACC;
            S_DRAIN: state_d = S_BIAS;
            S_BIAS: begin
                state_d     = S_ACC;
                acc_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = relu_out;
            end
            default: state_d = S_ACC;
        endcase
    end

    // state registers; reset discards any partial vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            xd_q        <= '0;
            vd_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            xd_q        <= xd_d;
            vd_q        <= vd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
